cdr_sym_timer: RTL and testbench

Parametrised symbol-timing generator for the CDR path. It is the next generation of the CDR counter. It counts oversampling clocks within one symbol period and emits one-cycle strobes at NB_SMP programmable sampling positions, plus phase-detector, frequency-sync and symbol-boundary strobes. It also supports one-clock phase advance/retard corrections and glitch-free period and position updates at symbol boundaries.

---
 rtl/cdr_sym_timer.sv | 132 +++++++++++++
 tb/tb_cdr_sym_timer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_sym_timer.sv
// cdr_sym_timer: symbol-timing generator for the CDR path.
// The block counts oversampling clocks within one symbol. It emits registered
// one-cycle strobes at NB_SMP programmable sample positions, plus
// phase-detector, frequency-sync and symbol-boundary strobes. It accepts
// single-clock advance/retard corrections. Period and position changes are
// applied only at symbol boundaries.
module cdr_sym_timer #(
    parameter int CNT_W  = 6,
    parameter int NB_SMP = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [CNT_W-1:0]        i_period,
    input  logic [NB_SMP*CNT_W-1:0] i_smp_pos,
    input  logic                    i_adj_valid,
    input  logic                    i_adj_dir,
    output logic [NB_SMP-1:0]       o_smp_en,
    output logic                    o_pd_en,
    output logic                    o_fs_en,
    output logic                    o_sym,
    output logic [CNT_W-1:0]        o_cnt,
    output logic                    o_adj_pend
);

    localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(4);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  pos_q [NB_SMP];
    logic [CNT_W-1:0]  pos_d [NB_SMP];
    logic              pend_q, pend_d;
    logic              dir_q, dir_d;
    logic [NB_SMP-1:0] smp_q, smp_d;
    logic              pd_q, pd_d;
    logic              fs_q, fs_d;
    logic              sym_q, sym_d;

    logic [CNT_W-1:0]  per_clamp;
    logic [CNT_W-1:0]  end_cnt;
    logic              wrap;

    // Clamp the requested period and pick this symbol's terminal count from the pending correction
    always_comb begin
        per_clamp = (i_period < MIN_PER) ? MIN_PER : i_period;
        end_cnt   = per_q - CNT_W'(1);
        if (pend_q) begin
            end_cnt = dir_q ? (per_q - CNT_W'(2)) : per_q;
        end
        wrap = i_en && (cnt_q == end_cnt);
    end

    // Shadow period/positions reload while in reset and at every wrap, otherwise hold
    always_comb begin
        per_d = per_q;
        for (int k = 0; k < NB_SMP; k++) begin
            pos_d[k] = pos_q[k];
        end
        if (i_rst || wrap) begin
            per_d = per_clamp;
            for (int k = 0; k < NB_SMP; k++) begin
                pos_d[k] = i_smp_pos[k*CNT_W +: CNT_W];
            end
        end
    end

    // Counter advance, correction bookkeeping (wrap clears before a new request is taken) and strobe decodes
    always_comb begin
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pend_d = wrap ? 1'b0 : pend_q;
        dir_d  = dir_q;
        if (i_adj_valid) begin
            if (!pend_d) begin
                pend_d = 1'b1;
                dir_d  = i_adj_dir;
            end else if (i_adj_dir != dir_q) begin
                pend_d = 1'b0;
            end
        end

        smp_d = '0;
        for (int k = 0; k < NB_SMP; k++) begin
            smp_d[k] = i_en && (cnt_q == pos_q[k]);
        end
        pd_d  = i_en && (cnt_q == (end_cnt - CNT_W'(2)));
        fs_d  = i_en && (cnt_q == (end_cnt - CNT_W'(1)));
        sym_d = wrap;
    end

    // Counter, correction and strobe registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            dir_q  <= 1'b0;
            smp_q  <= '0;
            pd_q   <= 1'b0;
            fs_q   <= 1'b0;
            sym_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            dir_q  <= dir_d;
            smp_q  <= smp_d;
            pd_q   <= pd_d;
            fs_q   <= fs_d;
            sym_q  <= sym_d;
        end
    end

    // Shadow registers track the inputs during reset through their next-state logic
    always_ff @(posedge i_clk) begin
        per_q <= per_d;
        for (int k = 0; k < NB_SMP; k++) begin
            pos_q[k] <= pos_d[k];
        end
    end

    assign o_smp_en   = smp_q;
    assign o_pd_en    = pd_q;
    assign o_fs_en    = fs_q;
    assign o_sym      = sym_q;
    assign o_cnt      = cnt_q;
    assign o_adj_pend = pend_q;

endmodule

// File: tb/tb_cdr_sym_timer.sv
// Testbench for cdr_sym_timer.
// A symbol-level reference model is compared against the DUT on every cycle.
// Directed scenarios check strobe times and symbol lengths against literal values.
module tb_cdr_sym_timer;

    localparam int CNT_W  = 6;
    localparam int NB_SMP = 3;
    localparam logic [NB_SMP*CNT_W-1:0] POS_A = {6'd21, 6'd11, 6'd1};
    localparam logic [NB_SMP*CNT_W-1:0] POS_B = {6'd20, 6'd11, 6'd1};

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic [CNT_W-1:0]        period;
    logic [NB_SMP*CNT_W-1:0] smp_pos;
    logic                    adj_valid;
    logic                    adj_dir;
    logic [NB_SMP-1:0]       o_smp_en;
    logic                    o_pd_en;
    logic                    o_fs_en;
    logic                    o_sym;
    logic [CNT_W-1:0]        o_cnt;
    logic                    o_adj_pend;

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;

    cdr_sym_timer #(.CNT_W(CNT_W), .NB_SMP(NB_SMP)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_period    (period),
        .i_smp_pos   (smp_pos),
        .i_adj_valid (adj_valid),
        .i_adj_dir   (adj_dir),
        .o_smp_en    (o_smp_en),
        .o_pd_en     (o_pd_en),
        .o_fs_en     (o_fs_en),
        .o_sym       (o_sym),
        .o_cnt       (o_cnt),
        .o_adj_pend  (o_adj_pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: symbol length is the period plus the signed correction for that symbol
    int              m_cnt, m_per;
    int              m_pos [NB_SMP];
    bit              m_pend, m_dir;
    bit [NB_SMP-1:0] m_smp;
    bit              m_pd, m_fs, m_sym;
    bit              m_valid = 1'b0;

    always @(posedge clk) begin
        int p, last, corr;
        bit wrap;
        p = (int'(period) < 4) ? 4 : int'(period);
        if (rst) begin
            m_cnt  = 0;
            m_per  = p;
            for (int k = 0; k < NB_SMP; k++) m_pos[k] = int'(smp_pos[k*CNT_W +: CNT_W]);
            m_pend = 1'b0;
            m_dir  = 1'b0;
            m_smp  = '0;
            m_pd   = 1'b0;
            m_fs   = 1'b0;
            m_sym  = 1'b0;
        end else begin
            corr = m_pend ? (m_dir ? -1 : 1) : 0;
            last = m_per + corr - 1;
            for (int k = 0; k < NB_SMP; k++) m_smp[k] = en && (m_cnt == m_pos[k]);
            m_pd  = en && (m_cnt == last - 2);
            m_fs  = en && (m_cnt == last - 1);
            wrap  = en && (m_cnt == last);
            m_sym = wrap;
            if (wrap) begin
                m_cnt  = 0;
                m_per  = p;
                for (int k = 0; k < NB_SMP; k++) m_pos[k] = int'(smp_pos[k*CNT_W +: CNT_W]);
                m_pend = 1'b0;
            end else if (en) begin
                m_cnt = m_cnt + 1;
            end
            if (adj_valid) begin
                if (!m_pend) begin
                    m_pend = 1'b1;
                    m_dir  = adj_dir;
                end else if (m_dir != adj_dir) begin
                    m_pend = 1'b0;
                end
            end
        end
        m_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("cnt",      int'(o_cnt),      m_cnt);
            checkOutput("smp_en",   int'(o_smp_en),   int'(m_smp));
            checkOutput("pd_en",    int'(o_pd_en),    int'(m_pd));
            checkOutput("fs_en",    int'(o_fs_en),    int'(m_fs));
            checkOutput("sym",      int'(o_sym),      int'(m_sym));
            checkOutput("adj_pend", int'(o_adj_pend), int'(m_pend));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input int per,
                                 input logic [NB_SMP*CNT_W-1:0] pos);
        rst     = r;
        en      = e;
        period  = per[CNT_W-1:0];
        smp_pos = pos;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic requestAdj(input logic dir);
        adj_valid = 1'b1;
        adj_dir   = dir;
        @(negedge clk);
        adj_valid = 1'b0;
    endtask

    task automatic waitSym(output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_sym && n < 200);
        checkOutput("sym_seen", int'(o_sym), 1);
        t = cyc;
    endtask

    int exp_first [6] = '{2, 12, 22, 23, 24, 25};
    int first_t   [6];
    int second_t  [6];
    int times     [6][8];
    int counts    [6];
    logic [5:0] vec;
    int t0, t1, t2, t3, zc;

    initial begin
        adj_valid = 1'b0;
        adj_dir   = 1'b0;
        applyStimulus(1'b1, 1'b1, 25, POS_A);
        tick(3);

        // Basic pattern: P=25, pos {1,11,21}, continuous enable
        applyStimulus(1'b0, 1'b1, 25, POS_A);
        checkOutput("rst_cnt",  int'(o_cnt), 0);
        checkOutput("rst_outs", int'({o_sym, o_fs_en, o_pd_en, o_smp_en, o_adj_pend}), 0);
        for (int i = 0; i < 6; i++) begin
            first_t[i]  = -1;
            second_t[i] = -1;
        end
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            vec = {o_sym, o_fs_en, o_pd_en, o_smp_en};
            for (int b = 0; b < 6; b++) begin
                if (vec[b]) begin
                    if (first_t[b] < 0) first_t[b] = t;
                    else if (second_t[b] < 0) second_t[b] = t;
                end
            end
        end
        for (int b = 0; b < 6; b++) begin
            checkOutput("first_strobe_time",  first_t[b],  exp_first[b]);
            checkOutput("second_strobe_time", second_t[b], exp_first[b] + 25);
        end

        // Enable toggling 1/0: every strobe spaced 50 cycles
        for (int b = 0; b < 6; b++) counts[b] = 0;
        for (int i = 0; i < 160; i++) begin
            en = (i % 2 == 0);
            @(negedge clk);
            vec = {o_sym, o_fs_en, o_pd_en, o_smp_en};
            for (int b = 0; b < 6; b++) begin
                if (vec[b]) begin
                    if (counts[b] < 8) times[b][counts[b]] = cyc;
                    counts[b]++;
                end
            end
        end
        en = 1'b1;
        for (int b = 0; b < 6; b++) begin
            checkOutput("en_toggle_count", int'(counts[b] >= 3 && counts[b] <= 4), 1);
            for (int j = 1; j < counts[b] && j < 8; j++) begin
                checkOutput("en_toggle_spacing", times[b][j] - times[b][j-1], 50);
            end
        end

        // Advance at cnt=5: one 24-clock symbol, then back to 25
        waitSym(t0);
        tick(5);
        requestAdj(1'b1);
        checkOutput("adv_pend_set", int'(o_adj_pend), 1);
        waitSym(t1);
        checkOutput("adv_len", t1 - t0, 24);
        checkOutput("adv_pend_clr", int'(o_adj_pend), 0);
        waitSym(t2);
        checkOutput("adv_next_len", t2 - t1, 25);

        // Retard then advance cancels
        tick(5);
        requestAdj(1'b0);
        tick(2);
        requestAdj(1'b1);
        checkOutput("cancel_pend", int'(o_adj_pend), 0);
        waitSym(t3);
        checkOutput("cancel_len", t3 - t2, 25);

        // Two retards give a single 26-clock symbol
        tick(5);
        requestAdj(1'b0);
        tick(2);
        requestAdj(1'b0);
        checkOutput("dbl_ret_pend", int'(o_adj_pend), 1);
        waitSym(t0);
        checkOutput("dbl_ret_len", t0 - t3, 26);

        // Retard in the wrap cycle applies to the following symbol
        waitSym(t0);
        tick(24);
        requestAdj(1'b0);
        t1 = cyc;
        checkOutput("wrap_ret_sym", int'(o_sym), 1);
        checkOutput("wrap_ret_cur_len", t1 - t0, 25);
        checkOutput("wrap_ret_pend", int'(o_adj_pend), 1);
        waitSym(t2);
        checkOutput("wrap_ret_len", t2 - t1, 26);
        waitSym(t3);
        checkOutput("wrap_ret_after", t3 - t2, 25);

        // Period change mid-symbol takes effect after the next wrap
        waitSym(t0);
        tick(10);
        applyStimulus(1'b0, 1'b1, 16, POS_A);
        waitSym(t1);
        checkOutput("per_chg_cur", t1 - t0, 25);
        waitSym(t2);
        checkOutput("per_chg_new", t2 - t1, 16);
        applyStimulus(1'b0, 1'b1, 16, POS_B);
        waitSym(t3);
        checkOutput("per_chg_new2", t3 - t2, 16);
        zc = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (o_smp_en[2]) zc++;
        end
        checkOutput("pos_beyond_end", zc, 0);

        // Reset at cnt=13 with a pending retard, then P=3 behaves as P=4
        waitSym(t0);
        tick(5);
        requestAdj(1'b0);
        tick(7);
        checkOutput("pre_rst_cnt", int'(o_cnt), 13);
        applyStimulus(1'b1, 1'b1, 3, POS_A);
        tick(1);
        checkOutput("mid_rst_cnt",  int'(o_cnt), 0);
        checkOutput("mid_rst_pend", int'(o_adj_pend), 0);
        checkOutput("mid_rst_outs", int'({o_sym, o_fs_en, o_pd_en, o_smp_en}), 0);
        applyStimulus(1'b0, 1'b1, 3, POS_A);
        waitSym(t1);
        waitSym(t2);
        checkOutput("min_per_len", t2 - t1, 4);
        waitSym(t3);
        checkOutput("min_per_len2", t3 - t2, 4);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time %0t reached, expected completion before 400000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
